// File: rtl/dcache_dm_if.sv
// Core load/store port plus backing-memory handshake of the direct-mapped data cache.
// The slave modport is the cache's view; the master modport is the core/memory side.
interface dcache_dm_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 16
);
   logic                  readen_i;
   logic                  writeen_i;
   logic [ADDR_W-1:0]     addr_i;
   logic [DATA_W/8-1:0]   be_i;
   logic [DATA_W-1:0]     dato_i;
   logic [DATA_W-1:0]     dato_o;
   logic                  stall_o;
   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [ADDR_W-1:0]     mem_addr_o;
   logic [DATA_W/8-1:0]   mem_be_o;
   logic [DATA_W-1:0]     mem_dato_o;
   logic [DATA_W-1:0]     mem_dato_i;
   logic                  mem_ack_i;
   logic [CNT_W-1:0]      hit_cnt_o;
   logic [CNT_W-1:0]      miss_cnt_o;

   modport slave (
      input  readen_i, writeen_i, addr_i, be_i, dato_i, mem_dato_i, mem_ack_i,
      output dato_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
             mem_dato_o, hit_cnt_o, miss_cnt_o
   );

   modport master (
      output readen_i, writeen_i, addr_i, be_i, dato_i, mem_dato_i, mem_ack_i,
      input  dato_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
             mem_dato_o, hit_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped write-through no-write-allocate cache, one word per line.
// Read hits 0 cycles; misses/writes stall the core until mem_ack_i, min 3 cycles to release.
module dcache_dm #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int IDX_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   dcache_dm_if.slave    bus
);
   localparam int TAG_W = ADDR_W - IDX_W;
   localparam int LINES = 1 << IDX_W;
   localparam int BE_W  = DATA_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_data [LINES];
   logic [TAG_W-1:0]    r_tag  [LINES];
   logic [LINES-1:0]    r_valid;
   logic [CNT_W-1:0]    r_hit_cnt;
   logic [CNT_W-1:0]    r_miss_cnt;

   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic [DATA_W-1:0]   w_line;
   logic [DATA_W-1:0]   w_merged;
   logic                w_tag_hit;
   logic                w_rd;
   logic                w_hit;
   logic                w_stall;
   logic                w_req;
   logic                w_we;
   logic [DATA_W-1:0]   w_dato;

   assign w_idx     = bus.addr_i[IDX_W-1:0];
   assign w_tag     = bus.addr_i[ADDR_W-1:IDX_W];
   assign w_line    = r_data[w_idx];
   assign w_tag_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_rd      = bus.readen_i && !bus.writeen_i;
   assign w_hit     = w_rd && w_tag_hit;

   always_comb begin
      w_merged = w_line;
      for (int b = 0; b < BE_W; b++) begin
         if (bus.be_i[b]) w_merged[8*b +: 8] = bus.dato_i[8*b +: 8];
      end
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      w_req   = 1'b0;
      w_we    = 1'b0;
      w_dato  = '0;
      case (r_state)
         S_IDLE: begin
            if (bus.writeen_i) begin
               w_stall = 1'b1;
               w_next  = S_WRITE;
            end else if (bus.readen_i) begin
               if (w_tag_hit) begin
                  w_dato = w_line;
               end else begin
                  w_stall = 1'b1;
                  w_next  = S_FILL;
               end
            end
         end
         S_FILL: begin
            w_stall = 1'b1;
            w_req   = 1'b1;
            if (bus.mem_ack_i) w_next = S_DONE;
         end
         S_WRITE: begin
            w_stall = 1'b1;
            w_req   = 1'b1;
            w_we    = 1'b1;
            if (bus.mem_ack_i) w_next = S_DONE;
         end
         S_DONE: begin
            w_dato = w_line;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Address, data and enables come straight from the core, which holds them while stalled.
   assign bus.stall_o    = w_stall;
   assign bus.dato_o     = w_dato;
   assign bus.mem_req_o  = w_req;
   assign bus.mem_we_o   = w_we;
   assign bus.mem_addr_o = bus.addr_i;
   assign bus.mem_be_o   = bus.be_i;
   assign bus.mem_dato_o = bus.dato_i;
   assign bus.hit_cnt_o  = r_hit_cnt;
   assign bus.miss_cnt_o = r_miss_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_valid    <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_hit && r_hit_cnt != '1)
            r_hit_cnt <= r_hit_cnt + 1'b1;
         if (r_state == S_IDLE && w_rd && !w_tag_hit && r_miss_cnt != '1)
            r_miss_cnt <= r_miss_cnt + 1'b1;
         if (r_state == S_FILL && bus.mem_ack_i)
            r_valid[w_idx] <= 1'b1;
      end
   end

   // Data and tag arrays are never cleared; the valid bits alone qualify them.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (r_state == S_FILL && bus.mem_ack_i) begin
            r_data[w_idx] <= bus.mem_dato_i;
            r_tag[w_idx]  <= w_tag;
         end else if (r_state == S_WRITE && bus.mem_ack_i && w_tag_hit) begin
            r_data[w_idx] <= w_merged;
         end
      end
   end
endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: vector table through a scoreboard, a backing-memory responder,
// and hand-written reset-during-fill and counter-saturation sequences.
module tb_dcache_dm;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_dm_if #(.DATA_W(32), .ADDR_W(10), .CNT_W(4)) bus ();

   dcache_dm #(.DATA_W(32), .ADDR_W(10), .IDX_W(5), .CNT_W(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic        re;
      logic        we;
      logic [9:0]  addr;
      logic [3:0]  be;
      logic [31:0] dat;
      int          dly;
      logic        chk_dat;
      logic [31:0] exp_dat;
      int          exp_lat;
      int          exp_hits;
      int          exp_miss;
   } vec_t;

   typedef struct {
      logic        chk;
      logic [31:0] dat;
      int          lat;
   } exp_t;

   int          errors = 0;
   int          checks = 0;
   exp_t        sb[$];
   logic [31:0] bmem [1024];
   int          ack_dly = 0;
   int          resp_cnt = 0;
   bit          resp_en = 1'b1;
   logic [9:0]  cur_addr;
   logic        cur_we;
   logic [3:0]  cur_be;
   logic [31:0] cur_dat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic re, input logic we, input logic [9:0] addr,
                               input logic [3:0] be, input logic [31:0] dat, input int dly,
                               input logic chk, input logic [31:0] exp_dat, input int lat,
                               input int hits, input int miss);
      vec_t v;
      v.re = re; v.we = we; v.addr = addr; v.be = be; v.dat = dat; v.dly = dly;
      v.chk_dat = chk; v.exp_dat = exp_dat; v.exp_lat = lat;
      v.exp_hits = hits; v.exp_miss = miss;
      return v;
   endfunction

   // Backing memory: acks after ack_dly request cycles and checks the request fields.
   initial begin
      bus.mem_ack_i  = 1'b0;
      bus.mem_dato_i = '0;
      forever begin
         @(negedge clk);
         #1;
         if (resp_en) begin
            bus.mem_ack_i = 1'b0;
            if (bus.mem_req_o && !rst) begin
               check("mem_addr", {22'd0, bus.mem_addr_o}, {22'd0, cur_addr});
               check("mem_we", {31'd0, bus.mem_we_o}, {31'd0, cur_we});
               if (cur_we) begin
                  check("mem_be", {28'd0, bus.mem_be_o}, {28'd0, cur_be});
                  check("mem_dato", bus.mem_dato_o, cur_dat);
               end
               if (resp_cnt >= ack_dly) begin
                  bus.mem_ack_i = 1'b1;
                  resp_cnt = 0;
                  if (cur_we) begin
                     for (int b = 0; b < 4; b++)
                        if (cur_be[b]) bmem[cur_addr][8*b +: 8] = cur_dat[8*b +: 8];
                  end else begin
                     bus.mem_dato_i = bmem[cur_addr];
                  end
               end else begin
                  resp_cnt++;
               end
            end else begin
               resp_cnt = 0;
            end
         end
      end
   end

   task automatic run_op(input vec_t v);
      exp_t e;
      exp_t got;
      int   cyc;
      @(negedge clk);
      ack_dly  = v.dly;
      cur_addr = v.addr;
      cur_we   = v.we;
      cur_be   = v.be;
      cur_dat  = v.dat;
      bus.readen_i  = v.re;
      bus.writeen_i = v.we;
      bus.addr_i    = v.addr;
      bus.be_i      = v.be;
      bus.dato_i    = v.dat;
      e.chk = v.chk_dat;
      e.dat = v.exp_dat;
      e.lat = v.exp_lat;
      sb.push_back(e);
      #1;
      cyc = 0;
      while (bus.stall_o && cyc < 40) begin
         check("dato_while_stalled", bus.dato_o, 32'd0);
         @(negedge clk);
         #1;
         cyc++;
      end
      got = sb.pop_front();
      check("stall_cycles", cyc, got.lat);
      if (got.chk) check("dato", bus.dato_o, got.dat);
      check("mem_req_at_release", {31'd0, bus.mem_req_o}, 32'd0);
      @(posedge clk);
      #1;
      check("hit_cnt", {28'd0, bus.hit_cnt_o}, v.exp_hits);
      check("miss_cnt", {28'd0, bus.miss_cnt_o}, v.exp_miss);
      bus.readen_i  = 1'b0;
      bus.writeen_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl [14];
      vec_t v;
      int   cyc;

      for (int i = 0; i < 1024; i++) bmem[i] = 32'hA5000000 | i;
      bmem[10'h005] = 32'hDEADBEEF;
      bmem[10'h025] = 32'h12345678;
      bmem[10'h100] = 32'h5555AAAA;

      //         re    we    addr    be       dat           dly chk  exp_dat        lat h  m
      tbl[0]  = mk(1'b1, 1'b0, 10'h005, 4'b0000, 32'h0,        0, 1'b1, 32'hDEADBEEF, 2, 0, 1);
      tbl[1]  = mk(1'b1, 1'b0, 10'h005, 4'b0000, 32'h0,        0, 1'b1, 32'hDEADBEEF, 0, 1, 1);
      tbl[2]  = mk(1'b0, 1'b1, 10'h005, 4'b0001, 32'h000000AA, 0, 1'b0, 32'h0,        2, 1, 1);
      tbl[3]  = mk(1'b1, 1'b0, 10'h005, 4'b0000, 32'h0,        0, 1'b1, 32'hDEADBEAA, 0, 2, 1);
      tbl[4]  = mk(1'b1, 1'b0, 10'h025, 4'b0000, 32'h0,        2, 1'b1, 32'h12345678, 4, 2, 2);
      tbl[5]  = mk(1'b1, 1'b0, 10'h005, 4'b0000, 32'h0,        0, 1'b1, 32'hDEADBEAA, 2, 2, 3);
      tbl[6]  = mk(1'b0, 1'b1, 10'h100, 4'b1111, 32'hCAFEF00D, 0, 1'b0, 32'h0,        2, 2, 3);
      tbl[7]  = mk(1'b1, 1'b0, 10'h100, 4'b0000, 32'h0,        0, 1'b1, 32'hCAFEF00D, 2, 2, 4);
      tbl[8]  = mk(1'b1, 1'b0, 10'h100, 4'b0000, 32'h0,        0, 1'b1, 32'hCAFEF00D, 0, 3, 4);
      tbl[9]  = mk(1'b1, 1'b1, 10'h100, 4'b1100, 32'h11223344, 1, 1'b0, 32'h0,        3, 3, 4);
      tbl[10] = mk(1'b1, 1'b0, 10'h100, 4'b0000, 32'h0,        0, 1'b1, 32'h1122F00D, 0, 4, 4);
      tbl[11] = mk(1'b0, 1'b1, 10'h025, 4'b0011, 32'h0000ABCD, 0, 1'b0, 32'h0,        2, 4, 4);
      tbl[12] = mk(1'b1, 1'b0, 10'h005, 4'b0000, 32'h0,        0, 1'b1, 32'hDEADBEAA, 0, 5, 4);
      tbl[13] = mk(1'b1, 1'b0, 10'h025, 4'b0000, 32'h0,        0, 1'b1, 32'h1234ABCD, 2, 5, 5);

      rst = 1'b1;
      bus.readen_i  = 1'b0;
      bus.writeen_i = 1'b0;
      bus.addr_i    = '0;
      bus.be_i      = '0;
      bus.dato_i    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_stall", {31'd0, bus.stall_o}, 32'd0);
      check("reset_dato", bus.dato_o, 32'd0);
      check("reset_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
      check("reset_hit_cnt", {28'd0, bus.hit_cnt_o}, 32'd0);
      check("reset_miss_cnt", {28'd0, bus.miss_cnt_o}, 32'd0);

      for (int i = 0; i < 14; i++) run_op(tbl[i]);

      // Reset in the middle of a fill; the memory's ack then arrives too late.
      resp_en = 1'b0;
      bus.mem_ack_i = 1'b0;
      @(negedge clk);
      bus.readen_i = 1'b1;
      bus.addr_i   = 10'h045;
      #1;
      check("rfill_stall_idle", {31'd0, bus.stall_o}, 32'd1);
      repeat (2) begin
         @(negedge clk);
         #1;
         check("rfill_mem_req", {31'd0, bus.mem_req_o}, 32'd1);
         check("rfill_mem_addr", {22'd0, bus.mem_addr_o}, 32'h045);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rfill_req_dropped", {31'd0, bus.mem_req_o}, 32'd0);
      check("rfill_hit_cnt", {28'd0, bus.hit_cnt_o}, 32'd0);
      check("rfill_miss_cnt", {28'd0, bus.miss_cnt_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.readen_i = 1'b0;
      bus.mem_ack_i  = 1'b1;
      bus.mem_dato_i = 32'hBAD0BAD0;
      @(posedge clk);
      #1;
      check("late_ack_req", {31'd0, bus.mem_req_o}, 32'd0);
      check("late_ack_stall", {31'd0, bus.stall_o}, 32'd0);
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      resp_en = 1'b1;

      v = mk(1'b1, 1'b0, 10'h005, 4'b0000, 32'h0, 0, 1'b1, 32'hDEADBEAA, 2, 0, 1);
      run_op(v);

      // Hit counter is 4 bits wide here, so it must stick at 15.
      for (int i = 1; i <= 17; i++) begin
         v = mk(1'b1, 1'b0, 10'h005, 4'b0000, 32'h0, 0, 1'b1, 32'hDEADBEAA, 0,
                (i > 15) ? 15 : i, 1);
         run_op(v);
      end

      cyc = sb.size();
      check("scoreboard_empty", cyc, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
Parametrised direct-mapped, write-through, no-write-allocate data cache for the single-cycle core, one word per line. It sits between the core's load/store port and a slower backing data memory. Read hits return data combinationally in the same cycle, with no stall. Misses and all writes stall the core through a request/acknowledge handshake to the backing memory. Hit and miss counters are provided for performance measurement.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 10, word address width.
IDX_W, 5, index width; the cache holds 2**IDX_W lines; tag width is ADDR_W-IDX_W.
CNT_W, 16, width of the hit and miss counters.

Ports:
clk_i  in  1  clock; all state changes on the rising edge
rst_i  in  1  synchronous reset, active-high
readen_i  in  1  load request
writeen_i  in  1  store request; takes priority over readen_i
addr_i  in  ADDR_W  word address
be_i  in  DATA_W/8  byte enables for stores
dato_i  in  DATA_W  store data
dato_o  out  DATA_W  load data
stall_o  out  1  core must hold its request while this is high
mem_req_o  out  1  backing memory request
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  ADDR_W  backing memory address
mem_be_o  out  DATA_W/8  backing memory byte enables
mem_dato_o  out  DATA_W  backing memory write data
mem_dato_i  in  DATA_W  backing memory read data
mem_ack_i  in  1  one-cycle completion pulse from backing memory
hit_cnt_o  out  CNT_W  read-hit count
miss_cnt_o  out  CNT_W  read-miss count

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Storage per line: data[DATA_W], tag[ADDR_W-IDX_W], valid bit. Index = addr_i[IDX_W-1:0]; tag = upper address bits. Valid bits are flops.
- Reset effects:
  - All valid bits cleared in one edge; data and tag arrays are not cleared.
  - State goes to IDLE; mem_req_o=0; both counters=0.
  - Outputs after reset: stall_o=0, dato_o=0.
- Hit = readen_i & ~writeen_i & valid[idx] & (tag[idx]==addr tag).
- dato_o = line data when (state IDLE and hit) or state DONE; otherwise 0.
- FSM states: IDLE, FILL, WRITE, DONE.
  - IDLE, read hit: stay in IDLE; stall_o=0; hit_cnt increments at the edge.
  - IDLE, read miss: stall_o=1 combinationally in that cycle; next edge -> FILL; miss_cnt increments at that edge.
  - IDLE, writeen_i (hit or miss): stall_o=1; next edge -> WRITE.
  - FILL: mem_req_o=1, mem_we_o=0, mem_addr_o=addr_i, stall_o=1. On an edge with mem_ack_i=1: write mem_dato_i into the line, update the tag, set valid, -> DONE.
  - WRITE: mem_req_o=1, mem_we_o=1, mem_addr_o=addr_i, mem_dato_o=dato_i, mem_be_o=be_i, stall_o=1. On an edge with mem_ack_i=1: if the tag matches and the line is valid, merge dato_i into the line by be_i; then -> DONE. A write miss never allocates.
  - DONE: stall_o=0, mem_req_o=0. For a read, dato_o shows the filled line. The request counts as complete (not re-issued, not counted as a hit). Next edge -> IDLE unconditionally.
- mem_* outputs hold stable while mem_req_o=1. mem_ack_i is ignored outside FILL and WRITE.
- Minimum latency:
  - Read hit: 0 cycles.
  - Read miss or write with ack in the first request cycle: 3 cycles from request to stall release (IDLE, FILL, DONE).
- Simultaneous readen_i and writeen_i: treated as a write; dato_o=0.
- Counters saturate at all ones.
- Reset during FILL or WRITE: return to IDLE and drop mem_req_o at the same edge; a late ack is ignored. Any partial write to the backing memory is the backing memory's concern.
- The core must hold addr_i, dato_i, be_i, readen_i and writeen_i constant while stall_o=1.

Test Plan:
- Reset, then read addr 0x005 -> miss; stall_o=1 for IDLE+FILL; mem_req_o=1 with mem_addr_o=0x005; ack with mem_dato_i=0xDEADBEEF -> DONE, dato_o=0xDEADBEEF, stall_o=0; miss_cnt=1.
- Read 0x005 again -> dato_o=0xDEADBEEF in the same cycle; stall_o=0; hit_cnt=1; no mem_req_o.
- Write 0x005, dato_i=0x000000AA, be_i=4'b0001 -> mem write issued with mem_be_o=0001; after ack, read 0x005 hits with 0xDEADBEAA.
- Read 0x025 (same index, different tag) -> miss; fill with 0x12345678. Then read 0x005 -> miss again; miss_cnt increments each time.
- Write to uncached 0x100 -> mem write only; a following read of 0x100 misses (no allocate).
- Assert rst_i during FILL with ack delayed 4 cycles -> mem_req_o=0 next edge; ack ignored; read 0x005 misses; counters=0.
